rr_arbiter4: RTL and testbench

- Four-requester round-robin arbiter with grant locking.
- Produces a registered one-hot grant vector that feeds directly into the 4-to-2 one-hot encoder stage (encoder4_2), which turns it into a 2-bit master index.
- Guarantees the encoder only ever sees a legal one-hot code or all-zeros. grant_valid qualifies the all-zeros case, because the encoder maps zero to index 00.

---
 rtl/arb_pkg.sv | 32 +++
 rtl/rr_pick4.sv | 17 +
 rtl/rr_arbiter4.sv | 128 ++++++++++++
 tb/tb_rr_arbiter4.sv | 289 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/arb_pkg.sv
// Shared definitions for the four-requester round-robin arbiter:
// FSM state codes, requester count and the rotate-and-find-first helper.
package arb_pkg;

   localparam int NUM_REQ = 4;

   localparam logic ST_IDLE  = 1'b0;
   localparam logic ST_GRANT = 1'b1;

   typedef struct packed {
      logic       any;
      logic [1:0] sel;
   } pick_t;

   // Rotate req so that bit ptr sits at position 0, take the lowest set bit,
   // then add ptr back to get the absolute requester index.
   function automatic pick_t rr_pick(input logic [NUM_REQ-1:0] req,
                                     input logic [1:0]         ptr);
      logic [2*NUM_REQ-1:0] dbl;
      logic [NUM_REQ-1:0]   rot;
      pick_t                p;
      dbl   = {req, req} >> ptr;
      rot   = dbl[NUM_REQ-1:0];
      p.any = |req;
      p.sel = 2'd0;
      for (int i = NUM_REQ - 1; i >= 0; i--) begin
         if (rot[i]) p.sel = ptr + 2'(i);
      end
      return p;
   endfunction

endpackage

// File: rtl/rr_pick4.sv
// Combinational round-robin pick: first asserted request at or after ptr.
module rr_pick4
   import arb_pkg::*;
(
   input  logic [NUM_REQ-1:0] req,
   input  logic [1:0]         ptr,
   output logic [1:0]         sel,
   output logic               any
);

   pick_t pick;

   assign pick = rr_pick(req, ptr);
   assign sel  = pick.sel;
   assign any  = pick.any;

endmodule

// File: rtl/rr_arbiter4.sv
// Four-requester round-robin arbiter with grant locking and a registered
// one-hot grant. Optional forced release after MAX_HOLD cycles: ARB_TIMEOUT_EN.
//
// state    | meaning
// ST_IDLE  | no grant; arbitrate among pending requests this cycle
// ST_GRANT | one master holds the grant until its request drops
module rr_arbiter4
   import arb_pkg::*;
#(
   parameter int MAX_HOLD = 15,
   parameter int CNT_W    = 4
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic [NUM_REQ-1:0] req,
   output logic [NUM_REQ-1:0] grant,
   output logic               grant_valid
`ifdef ARB_TIMEOUT_EN
   ,
   output logic               timeout
`endif
);

   if (MAX_HOLD < 2 || MAX_HOLD > (1 << CNT_W) - 1) begin : g_bad_param
      $error("rr_arbiter4: MAX_HOLD must lie in 2..2**CNT_W-1");
   end

   logic               state_q, state_d;
   logic [1:0]         ptr_q, ptr_d;
   logic [NUM_REQ-1:0] grant_q, grant_d;
   logic               grant_valid_q, grant_valid_d;
   logic [1:0]         pick_sel;
   logic               pick_any;
   logic               holder_req;

`ifdef ARB_TIMEOUT_EN
   localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(MAX_HOLD - 1);
   localparam logic [CNT_W-1:0] CNT_MAX   = {CNT_W{1'b1}};

   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             timeout_q, timeout_d;
`endif

   rr_pick4 u_pick (
      .req (req),
      .ptr (ptr_q),
      .sel (pick_sel),
      .any (pick_any)
   );

   // Only the current holder's request matters while locked.
   assign holder_req = |(req & grant_q);

   always_comb begin
      state_d   = state_q;
      ptr_d     = ptr_q;
      grant_d   = grant_q;
`ifdef ARB_TIMEOUT_EN
      cnt_d     = cnt_q;
      timeout_d = 1'b0;
`endif
      case (state_q)
         ST_IDLE: begin
            if (pick_any) begin
               state_d = ST_GRANT;
               grant_d = NUM_REQ'(1) << pick_sel;
               ptr_d   = pick_sel + 2'd1;
`ifdef ARB_TIMEOUT_EN
               cnt_d   = '0;
`endif
            end
         end
         ST_GRANT: begin
            if (!holder_req) begin
               state_d = ST_IDLE;
               grant_d = '0;
            end
`ifdef ARB_TIMEOUT_EN
            else if (cnt_q == HOLD_LAST) begin
               state_d   = ST_IDLE;
               grant_d   = '0;
               timeout_d = 1'b1;
            end
            else if (cnt_q != CNT_MAX) begin
               cnt_d = cnt_q + CNT_W'(1);
            end
`endif
         end
         default: begin
            state_d = ST_IDLE;
            grant_d = '0;
         end
      endcase
      grant_valid_d = |grant_d;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q       <= ST_IDLE;
         ptr_q         <= 2'd0;
         grant_q       <= '0;
         grant_valid_q <= 1'b0;
      end else begin
         state_q       <= state_d;
         ptr_q         <= ptr_d;
         grant_q       <= grant_d;
         grant_valid_q <= grant_valid_d;
      end
   end

`ifdef ARB_TIMEOUT_EN
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_q     <= '0;
         timeout_q <= 1'b0;
      end else begin
         cnt_q     <= cnt_d;
         timeout_q <= timeout_d;
      end
   end

   assign timeout = timeout_q;
`endif

   assign grant       = grant_q;
   assign grant_valid = grant_valid_q;

endmodule

// File: tb/tb_rr_arbiter4.sv
// Self-checking bench for rr_arbiter4: directed scenarios plus randomized
// request traffic against a behavioural arbiter model.
module tb_rr_arbiter4;

   localparam int MAX_HOLD = 15;
   localparam int CNT_W    = 4;
`ifdef ARB_TIMEOUT_EN
   localparam bit TO_EN = 1'b1;
`else
   localparam bit TO_EN = 1'b0;
`endif

   logic       clk   = 1'b0;
   logic       rst_n = 1'b0;
   logic [3:0] req   = 4'b0000;
   logic [3:0] grant;
   logic       grant_valid;
`ifdef ARB_TIMEOUT_EN
   logic       timeout;
`endif

   int n_checks = 0;
   int n_pass   = 0;

   // Model: index of current holder (-1 when idle), next-priority index,
   // cycles held so far, and whether the last edge was a forced release.
   int m_holder = -1;
   int m_ptr    = 0;
   int m_cnt    = 0;
   bit m_to     = 1'b0;

   always #5 clk = ~clk;

   rr_arbiter4 #(.MAX_HOLD(MAX_HOLD), .CNT_W(CNT_W)) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .req         (req),
      .grant       (grant),
      .grant_valid (grant_valid)
`ifdef ARB_TIMEOUT_EN
      ,
      .timeout     (timeout)
`endif
   );

   always @(negedge clk) begin
      n_checks++;
      if (!$onehot0(grant) || grant_valid !== (|grant))
         $display("FAIL onehot_invariant: grant=%b grant_valid=%b required onehot0 grant and grant_valid=|grant",
                  grant, grant_valid);
      else
         n_pass++;
   end

   function automatic logic [3:0] m_grant();
      return (m_holder < 0) ? 4'b0000 : 4'(1 << m_holder);
   endfunction

   task automatic model_reset();
      m_holder = -1;
      m_ptr    = 0;
      m_cnt    = 0;
      m_to     = 1'b0;
   endtask

   task automatic model_edge(input logic [3:0] r);
      bit found;
      m_to  = 1'b0;
      found = 1'b0;
      if (m_holder < 0) begin
         for (int k = 0; k < 4; k++) begin
            int idx;
            idx = (m_ptr + k) % 4;
            if (!found && r[idx]) begin
               found    = 1'b1;
               m_holder = idx;
               m_ptr    = (idx + 1) % 4;
               m_cnt    = 0;
            end
         end
      end else if (!r[m_holder]) begin
         m_holder = -1;
      end else if (TO_EN && m_cnt == MAX_HOLD - 1) begin
         m_holder = -1;
         m_to     = 1'b1;
      end else if (m_cnt < (1 << CNT_W) - 1) begin
         m_cnt++;
      end
   endtask

   task automatic tick(input logic [3:0] r);
      req = r;
      @(posedge clk);
      model_edge(r);
      #1;
   endtask

   task automatic do_reset();
      req   = 4'b0000;
      rst_n = 1'b0;
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      model_reset();
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      req   = 4'b1111;
      repeat (3) @(posedge clk);
      #1;
      n_checks++;
      if (grant !== 4'b0000 || grant_valid !== 1'b0)
         $display("FAIL reset_outputs: grant=%b valid=%b required 0000/0", grant, grant_valid);
      else n_pass++;
      rst_n = 1'b1;
      model_reset();
      tick(4'b1111);
      n_checks++;
      if (grant !== 4'b0001 || grant !== m_grant() || grant_valid !== 1'b1)
         $display("FAIL reset_first_grant: grant=%b valid=%b required 0001/1", grant, grant_valid);
      else n_pass++;
   endtask

   task automatic test_single();
      do_reset();
      tick(4'b0100);
      n_checks++;
      if (grant !== 4'b0100 || grant_valid !== 1'b1)
         $display("FAIL single_latency: grant=%b valid=%b required 0100/1", grant, grant_valid);
      else n_pass++;
      repeat (4) begin
         tick(4'b0100);
         n_checks++;
         if (grant !== 4'b0100)
            $display("FAIL single_hold: grant=%b required 0100", grant);
         else n_pass++;
      end
      tick(4'b0000);
      n_checks++;
      if (grant !== 4'b0000 || grant_valid !== 1'b0)
         $display("FAIL single_release: grant=%b valid=%b required 0000/0", grant, grant_valid);
      else n_pass++;
   endtask

   task automatic test_rotation();
      logic [3:0] exp_seq [5] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
      do_reset();
      tick(4'b1111);
      for (int g = 0; g < 5; g++) begin
         for (int c = 0; c < 3; c++) begin
            n_checks++;
            if (grant !== exp_seq[g] || grant !== m_grant())
               $display("FAIL rotation_grant[%0d]: grant=%b required %b", g, grant, exp_seq[g]);
            else n_pass++;
            if (c < 2) tick(4'b1111);
         end
         tick(4'b1111 & ~exp_seq[g]);
         n_checks++;
         if (grant !== 4'b0000)
            $display("FAIL rotation_bubble[%0d]: grant=%b required 0000", g, grant);
         else n_pass++;
         tick(4'b1111);
      end
   endtask

   task automatic test_lock();
      do_reset();
      tick(4'b0010);
      repeat (3) begin
         tick(4'b1010);
         n_checks++;
         if (grant !== 4'b0010)
            $display("FAIL lock_hold: grant=%b required 0010", grant);
         else n_pass++;
      end
      tick(4'b1000);
      n_checks++;
      if (grant !== 4'b0000)
         $display("FAIL lock_bubble: grant=%b required 0000", grant);
      else n_pass++;
      tick(4'b1000);
      n_checks++;
      if (grant !== 4'b1000 || grant !== m_grant())
         $display("FAIL lock_next: grant=%b required 1000", grant);
      else n_pass++;
   endtask

   task automatic test_reset_mid();
      do_reset();
      tick(4'b1000);
      rst_n = 1'b0;
      #1;
      n_checks++;
      if (grant !== 4'b0000 || grant_valid !== 1'b0)
         $display("FAIL reset_async: grant=%b valid=%b required 0000/0", grant, grant_valid);
      else n_pass++;
      #4 rst_n = 1'b1;
      model_reset();
      tick(4'b1001);
      n_checks++;
      if (grant !== 4'b0001)
         $display("FAIL reset_mid_ptr: grant=%b required 0001", grant);
      else n_pass++;
      // Pointer left at 2 by a grant to master 1 must return to 0.
      tick(4'b0000);
      tick(4'b0010);
      rst_n = 1'b0;
      #5 rst_n = 1'b1;
      model_reset();
      tick(4'b0101);
      n_checks++;
      if (grant !== 4'b0001 || grant !== m_grant())
         $display("FAIL reset_ptr_clear: grant=%b required 0001", grant);
      else n_pass++;
   endtask

   task automatic test_timeout();
      do_reset();
      tick(4'b0011);
      n_checks++;
      if (grant !== 4'b0001)
         $display("FAIL timeout_first: grant=%b required 0001", grant);
      else n_pass++;
`ifdef ARB_TIMEOUT_EN
      repeat (MAX_HOLD - 1) begin
         tick(4'b0011);
         n_checks++;
         if (grant !== 4'b0001 || timeout !== 1'b0)
            $display("FAIL timeout_hold: grant=%b timeout=%b required 0001/0", grant, timeout);
         else n_pass++;
      end
      tick(4'b0011);
      n_checks++;
      if (grant !== 4'b0000 || timeout !== 1'b1)
         $display("FAIL timeout_pulse: grant=%b timeout=%b required 0000/1", grant, timeout);
      else n_pass++;
      tick(4'b0011);
      n_checks++;
      if (grant !== 4'b0010 || timeout !== 1'b0)
         $display("FAIL timeout_next: grant=%b timeout=%b required 0010/0", grant, timeout);
      else n_pass++;
`else
      repeat (110) begin
         tick(4'b0011);
         n_checks++;
         if (grant !== 4'b0001)
            $display("FAIL hold_forever: grant=%b required 0001", grant);
         else n_pass++;
      end
`endif
   endtask

   task automatic test_random();
      logic [3:0] r;
      do_reset();
      r = 4'($urandom_range(0, 15));
      for (int n = 0; n < 3000; n++) begin
         for (int b = 0; b < 4; b++)
            if ($urandom_range(0, 3) == 0) r[b] = ~r[b];
         tick(r);
         n_checks++;
         if (grant !== m_grant() || grant_valid !== (m_holder >= 0))
            $display("FAIL random[%0d]: req=%b grant=%b valid=%b required %b/%b",
                     n, r, grant, grant_valid, m_grant(), (m_holder >= 0));
         else n_pass++;
`ifdef ARB_TIMEOUT_EN
         n_checks++;
         if (timeout !== m_to)
            $display("FAIL random_timeout[%0d]: timeout=%b required %b", n, timeout, m_to);
         else n_pass++;
`endif
      end
   endtask

   initial begin
      #2;
      test_reset();
      test_single();
      test_rotation();
      test_lock();
      test_reset_mid();
      test_timeout();
      test_random();
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
